// File: rtl/lane_hit_judge_if.sv
// -----------------------------------------------------------------------------
// lane_hit_judge_if
// Bundles the per-lane game-control inputs and judgement/score outputs of
// lane_hit_judge. clk and rst stay plain ports on the module.
//
//   restart          master->slave  restart game (acts as reset)
//   stop_or_endgame  master->slave  freeze judging and counters
//   block_h[9:0]     master->slave  block height, 0 = top, 720 = parked
//   key              master->slave  debounced key level
//   hit_pulse        slave->master  one-cycle PERFECT/GOOD pulse
//   miss_pulse       slave->master  one-cycle MISS pulse
//   judge[1:0]       slave->master  last judgement (0 NONE,1 PERF,2 GOOD,3 MISS)
//   score[13:0]      slave->master  saturating lane score
//   combo[6:0]       slave->master  current combo
//   max_combo[6:0]   slave->master  best combo since reset/restart
// -----------------------------------------------------------------------------
interface lane_hit_judge_if;
   logic        restart;
   logic        stop_or_endgame;
   logic [9:0]  block_h;
   logic        key;
   logic        hit_pulse;
   logic        miss_pulse;
   logic [1:0]  judge;
   logic [13:0] score;
   logic [6:0]  combo;
   logic [6:0]  max_combo;

   // Game controller / block generator side.
   modport master (
      output restart, stop_or_endgame, block_h, key,
      input  hit_pulse, miss_pulse, judge, score, combo, max_combo
   );

   // Judge side.
   modport slave (
      input  restart, stop_or_endgame, block_h, key,
      output hit_pulse, miss_pulse, judge, score, combo, max_combo
   );
endinterface

// File: rtl/lane_hit_judge.sv
// -----------------------------------------------------------------------------
// lane_hit_judge
// Judges one lane's falling block against the lane key: PERFECT, GOOD or MISS,
// once per block, and keeps the lane score, current combo and best combo.
// All outputs are registered (decision on cycle-N inputs, visible at N+1).
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   lane_hit_judge_if.slave (restart, stop_or_endgame, block_h, key in;
//         hit_pulse, miss_pulse, judge, score, combo, max_combo out)
//
// Build option:
//   STRAY_PENALTY_EN  when defined, a stray key press (below the window while
//                     waiting, or after the block was judged) is punished like
//                     a miss without changing the block state; otherwise
//                     stray presses are ignored.
// -----------------------------------------------------------------------------
module lane_hit_judge #(
   parameter int unsigned GOOD_LO   = 560,
   parameter int unsigned GOOD_HI   = 680,
   parameter int unsigned PERF_LO   = 600,
   parameter int unsigned PERF_HI   = 640,
   parameter int unsigned PERF_PTS  = 3,
   parameter int unsigned GOOD_PTS  = 1,
   parameter int unsigned SCORE_MAX = 9999
) (
   input  logic           clk,
   input  logic           rst,
   lane_hit_judge_if.slave bus
);

   typedef enum logic {
      ST_WAIT,   // block not yet judged
      ST_DONE    // block judged; wait for respawn
   } state_e;

   localparam logic [1:0] J_NONE = 2'd0;
   localparam logic [1:0] J_PERF = 2'd1;
   localparam logic [1:0] J_GOOD = 2'd2;
   localparam logic [1:0] J_MISS = 2'd3;

   localparam logic [9:0]  GOOD_LO_W   = 10'(GOOD_LO);
   localparam logic [9:0]  GOOD_HI_W   = 10'(GOOD_HI);
   localparam logic [9:0]  PERF_LO_W   = 10'(PERF_LO);
   localparam logic [9:0]  PERF_HI_W   = 10'(PERF_HI);
   localparam logic [13:0] PERF_PTS_W  = 14'(PERF_PTS);
   localparam logic [13:0] GOOD_PTS_W  = 14'(GOOD_PTS);
   localparam logic [13:0] SCORE_MAX_W = 14'(SCORE_MAX);
   localparam logic [6:0]  COMBO_MAX   = 7'd127;

   state_e      state_q,  state_d;
   logic        key_q;
   logic [9:0]  prev_h_q, prev_h_d;
   logic        hit_q,    hit_d;
   logic        miss_q,   miss_d;
   logic [1:0]  judge_q,  judge_d;
   logic [13:0] score_q,  score_d;
   logic [6:0]  combo_q,  combo_d;
   logic [6:0]  max_q,    max_d;

   logic        key_edge;
   logic        respawn;
   logic        in_perf;
   logic        in_good;
   logic        late;
   logic [6:0]  combo_inc;
   logic [13:0] pts;
   logic [14:0] score_sum;

   assign key_edge = bus.key & ~key_q;
   // A block only ever moves down, so a smaller height means a new block.
   assign respawn  = (bus.block_h < prev_h_q);
   assign in_perf  = (bus.block_h >= PERF_LO_W) && (bus.block_h <= PERF_HI_W);
   assign in_good  = (bus.block_h >= GOOD_LO_W) && (bus.block_h <= GOOD_HI_W);
   assign late     = (bus.block_h > GOOD_HI_W);

   assign combo_inc = (combo_q == COMBO_MAX) ? combo_q : combo_q + 7'd1;
   assign pts       = in_perf ? PERF_PTS_W : GOOD_PTS_W;
   // One extra bit so the sum cannot wrap before the saturation compare.
   assign score_sum = {1'b0, score_q} + {1'b0, pts};

   // ---------------------------------------------------------------------------
   // Next-state / output decision
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      prev_h_d = prev_h_q;
      hit_d    = 1'b0;
      miss_d   = 1'b0;
      judge_d  = judge_q;
      score_d  = score_q;
      combo_d  = combo_q;
      max_d    = max_q;

      if (!bus.stop_or_endgame) begin
         prev_h_d = bus.block_h;

         if (respawn) begin
            // Any press in the respawn cycle belongs to neither block.
            state_d = ST_WAIT;
         end else begin
            unique case (state_q)
               ST_WAIT: begin
                  if (late) begin
                     // A press arriving together with the overrun is still late.
                     state_d = ST_DONE;
                     miss_d  = 1'b1;
                     judge_d = J_MISS;
                     combo_d = '0;
                  end else if (key_edge && in_good) begin
                     state_d = ST_DONE;
                     hit_d   = 1'b1;
                     judge_d = in_perf ? J_PERF : J_GOOD;
                     score_d = (score_sum > {1'b0, SCORE_MAX_W}) ? SCORE_MAX_W
                                                                  : score_sum[13:0];
                     combo_d = combo_inc;
                     max_d   = (combo_inc > max_q) ? combo_inc : max_q;
                  end else if (key_edge) begin
                     // Stray press above the window.
`ifdef STRAY_PENALTY_EN
                     miss_d  = 1'b1;
                     judge_d = J_MISS;
                     combo_d = '0;
`endif
                  end
               end
               ST_DONE: begin
                  if (key_edge) begin
                     // Stray press on an already judged block.
`ifdef STRAY_PENALTY_EN
                     miss_d  = 1'b1;
                     judge_d = J_MISS;
                     combo_d = '0;
`endif
                  end
               end
               default: state_d = ST_WAIT;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before this edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst || bus.restart) begin
         state_q  <= ST_WAIT;
         key_q    <= 1'b0;
         // Seeding with the live height stops the first block looking like a respawn.
         prev_h_q <= bus.block_h;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
         judge_q  <= J_NONE;
         score_q  <= '0;
         combo_q  <= '0;
         max_q    <= '0;
      end else begin
         // Tracked even while frozen so unpausing with the key held is not an edge.
         key_q    <= bus.key;
         state_q  <= state_d;
         prev_h_q <= prev_h_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
         judge_q  <= judge_d;
         score_q  <= score_d;
         combo_q  <= combo_d;
         max_q    <= max_d;
      end
   end

   assign bus.hit_pulse  = hit_q;
   assign bus.miss_pulse = miss_q;
   assign bus.judge      = judge_q;
   assign bus.score      = score_q;
   assign bus.combo      = combo_q;
   assign bus.max_combo  = max_q;

endmodule

// File: tb/tb_lane_hit_judge.sv
// -----------------------------------------------------------------------------
// tb_lane_hit_judge
// Directed scenarios followed by randomized lanes, each cycle compared against
// a behavioural model of the lane rules (judged flag, heights, integer score).
// Build with or without STRAY_PENALTY_EN to match the design under test.
// -----------------------------------------------------------------------------
module tb_lane_hit_judge;

   logic clk;
   logic rst;
   lane_hit_judge_if bus ();

   lane_hit_judge dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   bit m_judged;
   int m_prev;
   bit m_key;
   bit m_hit;
   bit m_miss;
   int m_judge;
   int m_score;
   int m_combo;
   int m_max;

`ifdef STRAY_PENALTY_EN
   localparam bit PENALTY = 1'b1;
`else
   localparam bit PENALTY = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_miss();
      m_miss  = 1'b1;
      m_judge = 3;
      m_combo = 0;
   endtask

   // Apply the lane rules to one cycle of inputs.
   task automatic model(input bit r, input bit st, input int h, input bit k);
      bit edge_k;
      int pts;
      if (r) begin
         m_judged = 1'b0; m_prev = h; m_key = 1'b0;
         m_hit = 1'b0; m_miss = 1'b0; m_judge = 0;
         m_score = 0; m_combo = 0; m_max = 0;
         return;
      end
      edge_k = k && !m_key;
      m_key  = k;
      m_hit  = 1'b0;
      m_miss = 1'b0;
      if (st) return;
      if (h < m_prev) begin
         m_judged = 1'b0;
      end else if (!m_judged && h > 680) begin
         model_miss();
         m_judged = 1'b1;
      end else if (!m_judged && edge_k && h >= 560) begin
         pts      = (h >= 600 && h <= 640) ? 3 : 1;
         m_hit    = 1'b1;
         m_judge  = (pts == 3) ? 1 : 2;
         m_score  = (m_score + pts > 9999) ? 9999 : m_score + pts;
         m_combo  = (m_combo == 127) ? 127 : m_combo + 1;
         if (m_combo > m_max) m_max = m_combo;
         m_judged = 1'b1;
      end else if (edge_k && PENALTY) begin
         model_miss();
      end
      m_prev = h;
   endtask

   // One clock: drive, model, then compare 1 time unit after the edge.
   task automatic step(input bit r, input bit rs, input bit st, input int h, input bit k);
      rst                 = r;
      bus.restart         = rs;
      bus.stop_or_endgame = st;
      bus.block_h         = 10'(h);
      bus.key             = k;
      model(r || rs, st, h, k);
      @(posedge clk);
      #1;
      chk("hit_pulse",  32'(bus.hit_pulse),  32'(m_hit));
      chk("miss_pulse", 32'(bus.miss_pulse), 32'(m_miss));
      chk("judge",      32'(bus.judge),      32'(m_judge));
      chk("score",      32'(bus.score),      32'(m_score));
      chk("combo",      32'(bus.combo),      32'(m_combo));
      chk("max_combo",  32'(bus.max_combo),  32'(m_max));
      chk("exclusive",  32'(bus.hit_pulse & bus.miss_pulse), 32'd0);
   endtask

   task automatic ramp(input int from, input int to, input int inc, input int press_at);
      for (int h = from; h <= to; h += inc)
         step(1'b0, 1'b0, 1'b0, h, (h == press_at));
   endtask

   task automatic restart_at(input int h);
      step(1'b0, 1'b1, 1'b0, h, 1'b0);
   endtask

   initial begin
      int h;
      int inc;
      rst = 1'b0;
      bus.restart = 1'b0;
      bus.stop_or_endgame = 1'b0;
      bus.block_h = 10'd0;
      bus.key = 1'b0;

      // Reset state.
      step(1'b1, 1'b0, 1'b0, 120, 1'b0);
      chk("rst_judge", 32'(bus.judge), 32'd0);
      chk("rst_score", 32'(bus.score), 32'd0);

      // Unpressed block: MISS right after 681, quiet to 720.
      ramp(121, 680, 1, -1);
      step(1'b0, 1'b0, 1'b0, 681, 1'b0);
      chk("tp1_miss",  32'(bus.miss_pulse), 32'd1);
      chk("tp1_judge", 32'(bus.judge),      32'd3);
      ramp(682, 720, 1, -1);

      // PERFECT at 620, second edge at 630 is stray.
      restart_at(120);
      ramp(130, 610, 10, -1);
      step(1'b0, 1'b0, 1'b0, 620, 1'b1);
      chk("tp2_hit",   32'(bus.hit_pulse), 32'd1);
      chk("tp2_judge", 32'(bus.judge),     32'd1);
      chk("tp2_score", 32'(bus.score),     32'd3);
      chk("tp2_max",   32'(bus.max_combo), 32'd1);
      step(1'b0, 1'b0, 1'b0, 625, 1'b0);
      step(1'b0, 1'b0, 1'b0, 630, 1'b1);
      chk("tp2_stray_hit", 32'(bus.hit_pulse), 32'd0);
      ramp(640, 720, 10, -1);

      // GOOD at both window edges, then a late press at 681.
      restart_at(120);
      ramp(130, 720, 10, 570);
      ramp(120, 720, 10, 680);
      chk("tp3_score", 32'(bus.score), 32'd2);
      chk("tp3_combo", 32'(bus.combo), 32'd2);
      chk("tp3_judge", 32'(bus.judge), 32'd2);
      ramp(121, 671, 10, -1);
      step(1'b0, 1'b0, 1'b0, 681, 1'b1);
      chk("tp3_late_miss", 32'(bus.miss_pulse), 32'd1);
      chk("tp3_late_hit",  32'(bus.hit_pulse),  32'd0);
      ramp(691, 720, 10, -1);

      // Three PERFECT, a MISS, one GOOD.
      restart_at(120);
      for (int i = 0; i < 3; i++) ramp(120, 720, 10, 620);
      ramp(120, 720, 10, -1);
      ramp(120, 720, 10, 570);
      chk("tp4_combo", 32'(bus.combo),     32'd1);
      chk("tp4_max",   32'(bus.max_combo), 32'd3);
      chk("tp4_score", 32'(bus.score),     32'd10);

      // Presses while frozen, unfreeze with key held: no hit, later MISS.
      restart_at(120);
      ramp(130, 600, 10, -1);
      step(1'b0, 1'b0, 1'b1, 610, 1'b1);
      step(1'b0, 1'b0, 1'b1, 610, 1'b0);
      step(1'b0, 1'b0, 1'b1, 610, 1'b1);
      step(1'b0, 1'b0, 1'b0, 620, 1'b1);
      chk("tp5_no_hit", 32'(bus.hit_pulse), 32'd0);
      chk("tp5_judge",  32'(bus.judge),     32'd0);
      for (int hh = 630; hh <= 720; hh += 10) step(1'b0, 1'b0, 1'b0, hh, 1'b1);
      chk("tp5_miss_judge", 32'(bus.judge), 32'd3);

      // Stray press below the window with combo 2.
      restart_at(120);
      ramp(120, 720, 10, 620);
      ramp(120, 720, 10, 620);
      ramp(120, 290, 10, -1);
      step(1'b0, 1'b0, 1'b0, 300, 1'b1);
      chk("tp6_stray_miss",  32'(bus.miss_pulse), PENALTY ? 32'd1 : 32'd0);
      chk("tp6_stray_combo", 32'(bus.combo),      PENALTY ? 32'd0 : 32'd2);
      ramp(310, 720, 10, 620);
      chk("tp6_judge", 32'(bus.judge), 32'd1);
      chk("tp6_score", 32'(bus.score), 32'd9);

      // Back-to-back PERFECT blocks until combo and score saturate.
      restart_at(600);
      for (int i = 0; i < 3400; i++) begin
         step(1'b0, 1'b0, 1'b0, 620, 1'b1);
         step(1'b0, 1'b0, 1'b0, 600, 1'b0);
      end
      chk("sat_combo", 32'(bus.combo),     32'd127);
      chk("sat_max",   32'(bus.max_combo), 32'd127);
      chk("sat_score", 32'(bus.score),     32'd9999);

      // Randomized lanes.
      restart_at(0);
      for (int b = 0; b < 300; b++) begin
         h = $urandom_range(0, 400);
         while (h <= 720) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 14) == 0), h, ($urandom_range(0, 2) == 0));
            inc = $urandom_range(1, 25);
            if (h < 720 && h + inc > 720) h = 720;
            else h = h + inc;
         end
         for (int p = 0; p < int'($urandom_range(0, 3)); p++)
            step(1'b0, 1'b0, ($urandom_range(0, 4) == 0), 720, ($urandom_range(0, 1) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lane_hit_judge.md
Name: lane_hit_judge

Overview:
- Downstream consumer of one lane's falling-block height (`block_h`, 0 = top, 720 = parked off-screen).
- Samples the lane's key and judges each block once: PERFECT, GOOD or MISS.
- Keeps the lane score, current combo and best combo.
- One instance per lane; the score aggregator and display sum or mux its outputs.

Parameters:
- GOOD_LO, 560, lowest `block_h` (inclusive) for a GOOD hit.
- GOOD_HI, 680, highest `block_h` (inclusive) for a GOOD hit; `block_h` > GOOD_HI while unjudged is a MISS.
- PERF_LO, 600, lowest `block_h` (inclusive) for a PERFECT hit; must lie within GOOD window.
- PERF_HI, 640, highest `block_h` (inclusive) for a PERFECT hit.
- PERF_PTS, 3, points added for PERFECT.
- GOOD_PTS, 1, points added for GOOD.
- SCORE_MAX, 9999, score saturation value.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- restart  in  1  synchronous; same effect as rst.
- stop_or_endgame  in  1  high = game paused or ended; freeze judging and counters.
- block_h  in  10  current height of this lane's block.
- key  in  1  debounced key level, high = pressed.
- hit_pulse  out  1  one-cycle pulse on PERFECT or GOOD.
- miss_pulse  out  1  one-cycle pulse on MISS.
- judge  out  2  last judgement: 0 NONE, 1 PERFECT, 2 GOOD, 3 MISS; held until next judgement.
- score  out  14  lane score, saturating at SCORE_MAX.
- combo  out  7  consecutive hits, saturating at 127.
- max_combo  out  7  highest combo reached since reset/restart.

Behaviour:
- Only one clock and one reset. The reset is synchronous and active-high. rst and restart act identically and take priority over everything else.
- Reset values:
  - state = WAIT; `key_d` = 0; `prev_h` = `block_h`.
  - hit_pulse = 0, miss_pulse = 0, judge = 0, score = 0, combo = 0, max_combo = 0.
- Key edge: `key_edge` = key & ~key_d. `key_d` updates every non-reset cycle, including while frozen, so releasing the pause never yields a phantom edge.
- Freeze: while stop_or_endgame = 1, state, score, combo, max_combo, judge and `prev_h` hold, and pulses are 0.
- Respawn: if `block_h` < `prev_h`, the block has respawned. State goes to WAIT and any `key_edge` in that cycle is ignored. `prev_h` <= `block_h` every unfrozen cycle.
- State WAIT (block not yet judged), evaluated when not respawning:
  - `key_edge` and PERF_LO <= `block_h` <= PERF_HI: PERFECT, score += PERF_PTS, goto DONE.
  - `key_edge` and `block_h` otherwise within GOOD_LO..GOOD_HI: GOOD, score += GOOD_PTS, goto DONE.
  - no `key_edge` and `block_h` > GOOD_HI: MISS, goto DONE.
  - `key_edge` and `block_h` < GOOD_LO: stray press, see optional feature; stay WAIT.
  - `key_edge` and `block_h` > GOOD_HI in the same cycle: MISS (the late press is not a hit).
- State DONE: remain until respawn. `key_edge` here is a stray press. A parked block at 720 stays DONE.
- On hit:
  - hit_pulse = 1 for one cycle.
  - judge updated.
  - combo += 1, saturating at 127.
  - max_combo = max(max_combo, new combo), same cycle.
- On MISS: miss_pulse = 1 for one cycle, judge = 3, combo = 0; score unchanged.
- Latency: decision uses the cycle-N inputs; all outputs are registered and visible at cycle N+1.
- Score arithmetic: 14-bit; if score + pts > SCORE_MAX then score = SCORE_MAX.
- hit_pulse and miss_pulse are never high together.

Optional Feature:
- STRAY_PENALTY_EN defined: a stray press (WAIT below window, or DONE) acts as a penalty: miss_pulse = 1, judge = 3, combo = 0; score unchanged; state unchanged.
- STRAY_PENALTY_EN undefined: stray presses are ignored entirely, with no output change.

Test Plan:
- Reset, `block_h` ramps 120→720 with no key -> at the cycle after `block_h` = 681: miss_pulse = 1, judge = 3, combo = 0, score = 0; no further pulses through 720.
- Key rising edge at `block_h` = 620 -> next cycle: hit_pulse = 1, judge = 1, score = 3, combo = 1, max_combo = 1; a second edge at 630 gives no pulse (define off).
- Edge at 570, then respawn to 120, then edge at 680 -> score = 1 after the first hit and 2 after the second, combo = 2, judge = 2; an edge exactly at 681 yields MISS.
- Three PERFECT blocks, then a MISS, then one GOOD -> combo 3→0→1, max_combo = 3, score = 10.
- stop_or_endgame = 1 with key pressed at `block_h` = 610, released and pressed again while frozen, then stop dropped with key held -> no judgement; block passes 681 unfrozen -> MISS.
- With STRAY_PENALTY_EN, combo = 2 and an edge at `block_h` = 300 -> miss_pulse = 1, combo = 0, score unchanged, state stays WAIT; a later edge at 620 scores PERFECT. Without the define: no response to the 300 edge.
